// File: rtl/ethernet_pt_debug_scan_master_if.sv
// ethernet_pt_debug_scan_master_if
// Bundles the command/response handshake and the virtual-JTAG signal set
// between the scan master and whoever issues commands / plays the slave.
//   cmd_valid/cmd_ready/cmd_ir/cmd_data : scan request handshake
//   rsp_valid/rsp_data                  : captured-word response (pulse + hold)
//   vji_tck/tdi/ir_in/uir/cdr/sdr/udr/rti : virtual-JTAG drive towards slave
//   vji_tdo                             : serial return from slave
// modport master : view taken by the scan master
// modport slave  : view taken by the command issuer / slave side
interface ethernet_pt_debug_scan_master_if #(
  parameter int SR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic [SR_WIDTH-1:0] rsp_data;
  logic                vji_tck;
  logic                vji_tdi;
  logic                vji_tdo;
  logic [1:0]          vji_ir_in;
  logic                vji_uir;
  logic                vji_cdr;
  logic                vji_sdr;
  logic                vji_udr;
  logic                vji_rti;

  modport master (
    input  cmd_valid, cmd_ir, cmd_data, vji_tdo,
    output cmd_ready, rsp_valid, rsp_data,
    output vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_data, vji_tdo,
    input  cmd_ready, rsp_valid, rsp_data,
    input  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );
endinterface

// File: rtl/ethernet_pt_debug_scan_master.sv
// ethernet_pt_debug_scan_master
// Clock-domain-local JTAG scan initiator. One accepted command runs a full
// UIR -> CDR -> SDR (SR_WIDTH bits) -> UDR -> RTI (RTI_CYCLES) sequence on the
// virtual-JTAG signal set and returns the word shifted in from vji_tdo.
// Ports:
//   clk   : system clock, all logic on rising edge
//   reset : synchronous active-high reset
//   bus   : ethernet_pt_debug_scan_master_if.master (command, response, vji_*)
// Each tck period is 2*TCK_DIV clk cycles: TCK_DIV low, then TCK_DIV high.
module ethernet_pt_debug_scan_master #(
  parameter int SR_WIDTH   = 38,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  ethernet_pt_debug_scan_master_if.master bus
);

  localparam int DIV_W   = $clog2(2 * TCK_DIV);
  localparam int CNT_MAX = (SR_WIDTH > RTI_CYCLES) ? SR_WIDTH : RTI_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [DIV_W-1:0] LOW_LAST   = DIV_W'(TCK_DIV - 1);
  localparam logic [DIV_W-1:0] HIGH_FIRST = DIV_W'(TCK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * TCK_DIV - 1);
  localparam logic [CNT_W-1:0] SR_LAST    = CNT_W'(SR_WIDTH - 1);
  localparam logic [CNT_W-1:0] RTI_LAST   = CNT_W'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, UIR, CDR, SDR, UDR, RTI, DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [DIV_W-1:0]    div_cnt;
  logic [CNT_W-1:0]    step_cnt;
  logic [1:0]          ir_q;
  logic [SR_WIDTH-1:0] tx;
  logic [SR_WIDTH-1:0] rx;
  logic [SR_WIDTH-1:0] rsp_q;
  logic                ready;
  logic                accept;
  logic                active;
  logic                period_end;
  logic                sample_pt;

  assign accept     = bus.cmd_valid & ready;
  assign active     = (state != IDLE) && (state != DONE);
  assign period_end = (div_cnt == DIV_LAST);
  // Last clk of the low phase: tdo is still the slave's pre-shift bit.
  assign sample_pt  = (div_cnt == LOW_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.cmd_valid) state_next = UIR;
      end
      UIR: if (period_end) state_next = CDR;
      CDR: if (period_end) state_next = SDR;
      SDR: if (period_end && step_cnt == SR_LAST) state_next = UDR;
      UDR: if (period_end) state_next = RTI;
      RTI: if (period_end && step_cnt == RTI_LAST) state_next = DONE;
      DONE: begin
        // A new command may chain straight into the next scan.
        ready      = 1'b1;
        state_next = bus.cmd_valid ? UIR : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control counters: phase within tck period and bit / RTI step index.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      step_cnt <= '0;
      ir_q     <= '0;
      rsp_q    <= '0;
    end else if (accept) begin
      div_cnt  <= '0;
      step_cnt <= '0;
      ir_q     <= bus.cmd_ir;
    end else if (active) begin
      div_cnt <= period_end ? '0 : div_cnt + 1'b1;
      if (period_end && (state == SDR || state == RTI))
        step_cnt <= (state == SDR && step_cnt == SR_LAST) ? '0 : step_cnt + 1'b1;
      if (period_end && state == RTI && step_cnt == RTI_LAST)
        rsp_q <= rx;
    end
  end

  // Shift datapath: tx drains LSB first, rx fills from the MSB end so the
  // first captured bit lands in bit 0 after SR_WIDTH shifts.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx <= bus.cmd_data;
    end else if (state == SDR) begin
      if (period_end) tx <= tx >> 1;
      if (sample_pt)  rx <= {bus.vji_tdo, rx[SR_WIDTH-1:1]};
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_data  = rsp_q;
  assign bus.vji_tck   = active && (div_cnt >= HIGH_FIRST);
  assign bus.vji_tdi   = (state == SDR) && tx[0];
  assign bus.vji_ir_in = active ? ir_q : 2'b00;
  assign bus.vji_uir   = (state == UIR);
  assign bus.vji_cdr   = (state == CDR);
  assign bus.vji_sdr   = (state == SDR);
  assign bus.vji_udr   = (state == UDR);
  assign bus.vji_rti   = (state == RTI);

endmodule

// File: tb/tb_ethernet_pt_debug_scan_master.sv
// tb_ethernet_pt_debug_scan_master
// Directed bench for the JTAG scan master: a default-parameter instance with a
// behavioural 38-bit debug slave (or tdo tied high), and a small instance
// (SR_WIDTH=4, TCK_DIV=1, RTI_CYCLES=1) with tdo looped back from tdi.
module tb_ethernet_pt_debug_scan_master;

  localparam logic [37:0] SLAVE_CAP = 38'h15_1234_5678;

  logic clk;
  logic reset;
  logic tie_one;
  logic [37:0] slave_sr;
  logic [37:0] slave_upd;

  int checks = 0;
  int passed = 0;

  int n_uir, n_cdr, n_sdr, n_udr, n_rti, n_rise;
  int n_irbad, n_multi, n_tdibad, n_busyready, n_glitch;
  int rsp_cyc;
  logic [37:0] rsp_word;
  int b_rise, b_sdr, b_rti, b_cyc;
  logic [3:0] b_word;

  ethernet_pt_debug_scan_master_if #(.SR_WIDTH(38)) a();
  ethernet_pt_debug_scan_master_if #(.SR_WIDTH(4))  b();

  ethernet_pt_debug_scan_master #(
    .SR_WIDTH(38), .TCK_DIV(2), .RTI_CYCLES(2)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a)
  );

  ethernet_pt_debug_scan_master #(
    .SR_WIDTH(4), .TCK_DIV(1), .RTI_CYCLES(1)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a.vji_tdo = tie_one ? 1'b1 : slave_sr[0];
  assign b.vji_tdo = b.vji_tdi;

  // Debug slave model: capture on cdr, shift on sdr, publish on udr.
  always @(posedge a.vji_tck) begin
    if (a.vji_cdr)      slave_sr <= SLAVE_CAP;
    else if (a.vji_sdr) slave_sr <= {a.vji_tdi, slave_sr[37:1]};
    if (a.vji_udr)      slave_upd <= slave_sr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] snap_a();
    return {a.cmd_ready, a.rsp_valid, a.vji_tck, a.vji_tdi, a.vji_ir_in,
            a.vji_uir, a.vji_cdr, a.vji_sdr, a.vji_udr, a.vji_rti};
  endfunction

  task automatic run_a(input logic [1:0] ir, input logic [37:0] data);
    logic prev_tck;
    logic [5:0] prev_sig;
    logic [5:0] sig;
    int nf;
    n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; n_rise = 0;
    n_irbad = 0; n_multi = 0; n_tdibad = 0; n_busyready = 0; n_glitch = 0;
    rsp_cyc = -1; rsp_word = '0; prev_tck = 1'b0; prev_sig = '0;
    @(negedge clk);
    a.cmd_ir = ir; a.cmd_data = data; a.cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      a.cmd_valid = 1'b0;
      sig = {a.vji_tdi, a.vji_uir, a.vji_cdr, a.vji_sdr, a.vji_udr, a.vji_rti};
      nf = 0;
      if (a.vji_uir) begin n_uir++; nf++; end
      if (a.vji_cdr) begin n_cdr++; nf++; end
      if (a.vji_sdr) begin n_sdr++; nf++; end
      if (a.vji_udr) begin n_udr++; nf++; end
      if (a.vji_rti) begin n_rti++; nf++; end
      if (nf > 1) n_multi++;
      if (nf == 1 && a.vji_ir_in !== ir) n_irbad++;
      if (nf == 0 && (a.vji_ir_in !== 2'b00 || a.vji_tck !== 1'b0)) n_irbad++;
      if (!a.vji_sdr && a.vji_tdi) n_tdibad++;
      if (nf != 0 && a.cmd_ready) n_busyready++;
      if (sig != prev_sig && a.vji_tck) n_glitch++;
      if (a.vji_tck && !prev_tck) n_rise++;
      prev_tck = a.vji_tck;
      prev_sig = sig;
      if (a.rsp_valid) begin
        rsp_cyc = cyc;
        rsp_word = a.rsp_data;
        break;
      end
    end
  endtask

  task automatic run_b(input logic [3:0] data);
    logic prev_tck;
    b_rise = 0; b_sdr = 0; b_rti = 0; b_cyc = -1; b_word = '0; prev_tck = 1'b0;
    @(negedge clk);
    b.cmd_ir = 2'b10; b.cmd_data = data; b.cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      b.cmd_valid = 1'b0;
      if (b.vji_sdr) b_sdr++;
      if (b.vji_rti) b_rti++;
      if (b.vji_tck && !prev_tck) b_rise++;
      prev_tck = b.vji_tck;
      if (b.rsp_valid) begin
        b_cyc = cyc;
        b_word = b.rsp_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (snap_a() !== 11'b100_0000_0000) $display("FAIL reset_initial: got %b want %b", snap_a(), 11'b100_0000_0000);
    else passed++;
    checks++;
    if (a.rsp_data !== 38'h0) $display("FAIL reset_rsp_data: got %h want 0", a.rsp_data);
    else passed++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (snap_a() !== 11'b100_0000_0000) $display("FAIL reset_idle: got %b want %b", snap_a(), 11'b100_0000_0000);
    else passed++;
    checks++;
    if ({b.cmd_ready, b.rsp_valid, b.vji_tck} !== 3'b100) $display("FAIL reset_small: got %b want 100", {b.cmd_ready, b.rsp_valid, b.vji_tck});
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tied_tdo();
    tie_one = 1'b1;
    run_a(2'b01, 38'h2A_5A5A_5A5A);
    checks++; if (n_uir !== 4) $display("FAIL uir_clks: got %0d want 4", n_uir); else passed++;
    checks++; if (n_cdr !== 4) $display("FAIL cdr_clks: got %0d want 4", n_cdr); else passed++;
    checks++; if (n_sdr !== 152) $display("FAIL sdr_clks: got %0d want 152", n_sdr); else passed++;
    checks++; if (n_udr !== 4) $display("FAIL udr_clks: got %0d want 4", n_udr); else passed++;
    checks++; if (n_rti !== 8) $display("FAIL rti_clks: got %0d want 8", n_rti); else passed++;
    checks++; if (n_rise !== 43) $display("FAIL tck_rises: got %0d want 43", n_rise); else passed++;
    checks++; if (rsp_cyc !== 173) $display("FAIL rsp_cycle: got %0d want 173", rsp_cyc); else passed++;
    checks++; if (rsp_word !== 38'h3F_FFFF_FFFF) $display("FAIL rsp_ones: got %h want %h", rsp_word, 38'h3F_FFFF_FFFF); else passed++;
    checks++; if (n_irbad !== 0) $display("FAIL ir_in_hold: got %0d bad cycles want 0", n_irbad); else passed++;
    checks++; if (n_multi !== 0) $display("FAIL one_flag: got %0d bad cycles want 0", n_multi); else passed++;
    checks++; if (n_tdibad !== 0) $display("FAIL tdi_outside_sdr: got %0d bad cycles want 0", n_tdibad); else passed++;
    checks++; if (n_busyready !== 0) $display("FAIL ready_busy: got %0d bad cycles want 0", n_busyready); else passed++;
    checks++; if (n_glitch !== 0) $display("FAIL change_tck_high: got %0d bad cycles want 0", n_glitch); else passed++;
    @(negedge clk);
    checks++;
    if ({a.cmd_ready, a.rsp_valid, a.rsp_data} !== {2'b10, 38'h3F_FFFF_FFFF})
      $display("FAIL rsp_hold: got ready=%b valid=%b data=%h want 1 0 %h", a.cmd_ready, a.rsp_valid, a.rsp_data, 38'h3F_FFFF_FFFF);
    else passed++;
  endtask

  task automatic test_slave_scan();
    tie_one = 1'b0;
    slave_upd = '0;
    run_a(2'b10, 38'h0A_DEAD_BEEF);
    checks++; if (rsp_word !== SLAVE_CAP) $display("FAIL slave_capture: got %h want %h", rsp_word, SLAVE_CAP); else passed++;
    checks++; if (slave_upd !== 38'h0A_DEAD_BEEF) $display("FAIL slave_update: got %h want %h", slave_upd, 38'h0A_DEAD_BEEF); else passed++;
    checks++; if (rsp_cyc !== 173) $display("FAIL slave_rsp_cycle: got %0d want 173", rsp_cyc); else passed++;
    checks++; if (n_irbad !== 0) $display("FAIL slave_ir_in: got %0d bad cycles want 0", n_irbad); else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int first_cyc;
    int second_cyc;
    int busy_ready;
    int ir_bad;
    logic [37:0] rsp1;
    logic [37:0] rsp2;
    logic [37:0] upd1;
    tie_one = 1'b0;
    first_cyc = -1; second_cyc = -1; busy_ready = 0; ir_bad = 0;
    rsp1 = '0; rsp2 = '0; upd1 = '0;
    @(negedge clk);
    a.cmd_ir = 2'b11; a.cmd_data = 38'h01_0203_0405; a.cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        a.cmd_ir = 2'b01;
        a.cmd_data = 38'h3C_CAFE_F00D;
      end
      if (a.cmd_ready && !a.rsp_valid) busy_ready++;
      if (first_cyc < 0 && (a.vji_uir | a.vji_cdr | a.vji_sdr | a.vji_udr | a.vji_rti) && a.vji_ir_in !== 2'b11) ir_bad++;
      if (a.rsp_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc; rsp1 = a.rsp_data; upd1 = slave_upd;
        end else begin
          second_cyc = cyc; rsp2 = a.rsp_data;
          a.cmd_valid = 1'b0;
          break;
        end
      end
    end
    a.cmd_valid = 1'b0;
    checks++; if (first_cyc !== 173) $display("FAIL b2b_first_cycle: got %0d want 173", first_cyc); else passed++;
    checks++; if (second_cyc !== 346) $display("FAIL b2b_second_cycle: got %0d want 346", second_cyc); else passed++;
    checks++; if (busy_ready !== 0) $display("FAIL b2b_ready_busy: got %0d bad cycles want 0", busy_ready); else passed++;
    checks++; if (ir_bad !== 0) $display("FAIL b2b_ir_latched: got %0d bad cycles want 0", ir_bad); else passed++;
    checks++; if (upd1 !== 38'h01_0203_0405) $display("FAIL b2b_first_word: got %h want %h", upd1, 38'h01_0203_0405); else passed++;
    checks++; if (slave_upd !== 38'h3C_CAFE_F00D) $display("FAIL b2b_second_word: got %h want %h", slave_upd, 38'h3C_CAFE_F00D); else passed++;
    checks++; if ({rsp1, rsp2} !== {SLAVE_CAP, SLAVE_CAP}) $display("FAIL b2b_rsp: got %h %h want %h", rsp1, rsp2, SLAVE_CAP); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    int seen_rsp;
    logic was_sdr;
    tie_one = 1'b0;
    seen_rsp = 0;
    was_sdr = 1'b0;
    @(negedge clk);
    a.cmd_ir = 2'b01; a.cmd_data = 38'h00_FFFF_0000; a.cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      a.cmd_valid = 1'b0;
      if (a.rsp_valid) seen_rsp++;
      was_sdr = a.vji_sdr;
    end
    checks++; if (was_sdr !== 1'b1) $display("FAIL mid_in_sdr: got %b want 1", was_sdr); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (snap_a() !== 11'b100_0000_0000) $display("FAIL mid_reset_outputs: got %b want %b", snap_a(), 11'b100_0000_0000);
    else passed++;
    checks++; if (a.rsp_data !== 38'h0) $display("FAIL mid_reset_rsp_data: got %h want 0", a.rsp_data); else passed++;
    reset = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (a.rsp_valid) seen_rsp++;
    end
    checks++; if (seen_rsp !== 0) $display("FAIL mid_no_rsp: got %0d pulses want 0", seen_rsp); else passed++;
    run_a(2'b10, 38'h2B_1357_9BDF);
    checks++; if (rsp_cyc !== 173) $display("FAIL mid_fresh_cycle: got %0d want 173", rsp_cyc); else passed++;
    checks++; if (rsp_word !== SLAVE_CAP) $display("FAIL mid_fresh_rsp: got %h want %h", rsp_word, SLAVE_CAP); else passed++;
    checks++; if (slave_upd !== 38'h2B_1357_9BDF) $display("FAIL mid_fresh_update: got %h want %h", slave_upd, 38'h2B_1357_9BDF); else passed++;
    @(negedge clk);
  endtask

  task automatic test_small_loopback();
    run_b(4'b1001);
    checks++; if (b_word !== 4'b1001) $display("FAIL small_rsp_1001: got %b want 1001", b_word); else passed++;
    checks++; if (b_cyc !== 17) $display("FAIL small_rsp_cycle: got %0d want 17", b_cyc); else passed++;
    checks++; if (b_rise !== 8) $display("FAIL small_tck_rises: got %0d want 8", b_rise); else passed++;
    checks++; if (b_sdr !== 8) $display("FAIL small_sdr_clks: got %0d want 8", b_sdr); else passed++;
    checks++; if (b_rti !== 2) $display("FAIL small_rti_clks: got %0d want 2", b_rti); else passed++;
    @(negedge clk);
    run_b(4'b0110);
    checks++; if (b_word !== 4'b0110) $display("FAIL small_rsp_0110: got %b want 0110", b_word); else passed++;
    checks++; if (b_cyc !== 17) $display("FAIL small_rsp_cycle2: got %0d want 17", b_cyc); else passed++;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    tie_one = 1'b1;
    slave_sr = '0;
    slave_upd = '0;
    a.cmd_valid = 1'b0; a.cmd_ir = 2'b00; a.cmd_data = '0;
    b.cmd_valid = 1'b0; b.cmd_ir = 2'b00; b.cmd_data = '0;
    repeat (4) @(negedge clk);
    test_reset();
    test_tied_tdo();
    test_slave_scan();
    test_back_to_back();
    test_reset_mid_scan();
    test_small_loopback();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ethernet_pt_debug_scan_master.md
# ethernet_pt_debug_scan_master

Clock-domain-local JTAG scan initiator that drives the virtual-JTAG signal set (tck, tdi, ir_in, uir, cdr, sdr, udr, rti) consumed by the CPU debug slave, and samples its tdo. Accepts a command holding a 2-bit IR opcode and a 38-bit data word, performs one complete IR-update/DR-capture/shift/update/run-test-idle sequence, and returns the captured 38-bit word. It sits in the simulation/self-test harness in place of the vendor JTAG hub and exercises the debug slave's TCK and sysclk paths end to end.

## Interface
Parameters:
- SR_WIDTH, 38, scan data-register length in bits (≥2)
- TCK_DIV, 2, clk cycles per tck half-period (≥1)
- RTI_CYCLES, 2, tck periods spent in run-test-idle after update (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master idle, command accepted when cmd_valid & cmd_ready
- cmd_ir  in  2  IR opcode for this scan
- cmd_data  in  SR_WIDTH  word shifted out on tdi, LSB first
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  SR_WIDTH  word captured from tdo, first bit in LSB
- vji_tck  out  1  generated test clock
- vji_tdi  out  1  serial data to slave
- vji_tdo  in  1  serial data from slave
- vji_ir_in  out  2  IR value presented to slave
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual-state flags

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RTI, DONE.
- IDLE: cmd_ready=1, all vji_* outputs 0. On handshake latch cmd_ir into vji_ir_in and cmd_data into tx shift register; go to UIR.
- Each of UIR, CDR, UDR and each RTI step occupies exactly one tck period; SDR occupies SR_WIDTH tck periods. Exactly one of uir/cdr/sdr/udr/rti high per period, held for the whole period.
- vji_ir_in held at latched cmd_ir from UIR through RTI; returns to 0 in DONE.
- SDR: at start of each period vji_tdi = tx[0]; on the last clk of the low phase, sample vji_tdo: rx <= {vji_tdo, rx[SR_WIDTH-1:1]}; at period end tx shifts right. Bit counter counts 0..SR_WIDTH-1, exits SDR after bit SR_WIDTH-1.
- vji_tdi = 0 outside SDR.
- RTI: RTI_CYCLES periods, counter reused.
- DONE: one clk; rsp_valid=1, rsp_data=rx, cmd_ready=1 (a new command may be accepted in DONE); next state IDLE or UIR if accepted.
- rsp_data holds last captured word until the next DONE.
- cmd_valid while busy is ignored (cmd_ready=0); no queuing.
- reset mid-scan: abandon sequence, no rsp_valid, next cycle all outputs at reset values.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, all vji_* = 0, state IDLE.
- tck period = 2·TCK_DIV clk: low for TCK_DIV clks then high for TCK_DIV clks; each period starts low. tck is 0 in IDLE/DONE.
- tdi and state flags change only at period start (tck low), stable across the rising edge.
- Handshake at edge 0 → UIR begins cycle 1. Total periods P = 3 + SR_WIDTH + RTI_CYCLES; rsp_valid high in cycle 2·TCK_DIV·P + 1.
- Defaults: P = 43, rsp_valid in cycle 173; back-to-back commands spaced 173 cycles.
- TCK_DIV=1: tck toggles every clk; tdo sampled in the low-phase clk.

## Test plan
- Reset: assert reset 3 cycles mid-idle → cmd_ready=1, rsp_valid=0, vji_tck=0, all flags 0.
- Defaults, cmd_ir=2'b01, cmd_data=38'h2A_5A5A_5A5A, vji_tdo tied 1 → uir high 4 clks, cdr 4, sdr 152, udr 4, rti 8; exactly 43 tck rising edges; rsp_valid in cycle 173 with rsp_data=38'h3F_FFFF_FFFF; ir_in=01 throughout.
- Slave model (38-bit reg, loads 38'h15_1234_5678 on cdr, shifts {tdi,sr[37:1]} on tck rise, tdo=sr[0]) with cmd_data=38'h0A_DEAD_BEEF → rsp_data=38'h15_1234_5678, model reg=38'h0A_DEAD_BEEF at udr.
- Back-to-back: cmd_valid held with two words → second accepted in DONE cycle 173, second rsp_valid in cycle 346; cmd_valid during busy never accepted.
- Reset at cycle 60 (mid-SDR) → next cycle all vji_* 0, cmd_ready=1, no rsp_valid; fresh command then completes normally.
- TCK_DIV=1, RTI_CYCLES=1, SR_WIDTH=4, cmd_data=4'b1001, tdo loopback of tdi → rsp_data=4'b1001, rsp_valid in cycle 2·8+1=17.
